// File: rtl/fprnd_sched.sv
// Round-robin share of one fprnd datapath among FADD/FMUL/CVT: S1 issue reg -> fprnd -> S2 result reg.
// Latency 2 cycles handshake-to-out_vld; out_rdy low stalls S2, then S1, then req_rdy when S1 is full.
module fprnd_sched #(
  parameter int NREQ = 3,
  parameter int TAGW = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_vld,
  output logic [NREQ-1:0]      req_rdy,
  input  logic [NREQ*81-1:0]   req_A,
  input  logic [NREQ-1:0]      req_rbit,
  input  logic [NREQ-1:0]      req_tail,
  input  logic [NREQ-1:0]      req_rndbit,
  input  logic [NREQ*3-1:0]    req_rmode,
  input  logic [NREQ*4-1:0]    req_fmt,
  input  logic [NREQ*TAGW-1:0] req_tag,
  input  logic [2:0]           csr_rmode,
  input  logic                 csr_clr_nx,
  input  logic                 flush,
  output logic [80:0]          rnd_A,
  output logic                 rnd_rbit,
  output logic                 rnd_tail,
  output logic                 rnd_rndbit,
  output logic [2:0]           rnd_rmode,
  output logic                 rnd_isDBL,
  output logic                 rnd_isEXT,
  output logic                 rnd_toDBL,
  output logic                 rnd_toSNG,
  input  logic [79:0]          rnd_B,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [79:0]          out_B,
  output logic [TAGW-1:0]      out_tag,
  output logic [1:0]           out_src,
  output logic                 fflag_nx
);

  typedef struct packed {
    logic [80:0]     a;
    logic            rbit;
    logic            tail;
    logic            rndbit;
    logic [2:0]      rmode;
    logic [3:0]      fmt;
    logic [TAGW-1:0] tag;
  } op_t;

  op_t             s1_op, nxt_op;
  logic            s1_vld;
  logic [1:0]      s1_src;
  logic            s2_vld;
  logic [79:0]     s2_b;
  logic [TAGW-1:0] s2_tag;
  logic [1:0]      s2_src;
  logic [1:0]      ptr;

  logic            s2_stall, s1_adv, s1_open;
  logic            gnt_vld, take;
  logic [1:0]      gnt_idx;
  logic [2:0]      gnt_rmode;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[1:0];
  endfunction

  assign s2_stall = s2_vld & ~out_rdy;
  assign s1_adv   = s1_vld & ~s2_stall;
  assign s1_open  = ~s1_vld | s1_adv;

  // Scan from the farthest slot back to ptr so the first requester at or after ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_vld[rr_idx(ptr, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx(ptr, k);
      end
    end
  end

  assign take = rst_n & s1_open & ~flush & gnt_vld;

  always_comb begin
    req_rdy = '0;
    if (take) req_rdy[gnt_idx] = 1'b1;
  end

  always_comb begin
    gnt_rmode     = req_rmode[int'(gnt_idx)*3 +: 3];
    nxt_op.a      = req_A[int'(gnt_idx)*81 +: 81];
    nxt_op.rbit   = req_rbit[gnt_idx];
    nxt_op.tail   = req_tail[gnt_idx];
    nxt_op.rndbit = req_rndbit[gnt_idx];
    nxt_op.rmode  = (gnt_rmode == 3'b111) ? csr_rmode : gnt_rmode;
    nxt_op.fmt    = req_fmt[int'(gnt_idx)*4 +: 4];
    nxt_op.tag    = req_tag[int'(gnt_idx)*TAGW +: TAGW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_op  <= '0;
      s1_src <= '0;
      ptr    <= '0;
    end else begin
      if (flush)        s1_vld <= 1'b0;
      else if (s1_open) s1_vld <= gnt_vld;
      if (take) begin
        s1_op  <= nxt_op;
        s1_src <= gnt_idx;
        ptr    <= rr_idx(gnt_idx, 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_b   <= '0;
      s2_tag <= '0;
      s2_src <= '0;
    end else begin
      if (s1_adv) begin
        s2_b   <= rnd_B;
        s2_tag <= s1_op.tag;
        s2_src <= s1_src;
      end
      if (flush)                  s2_vld <= 1'b0;
      else if (s1_adv)            s2_vld <= 1'b1;
      else if (s2_vld && out_rdy) s2_vld <= 1'b0;
    end
  end

  // Clear wins over a same-cycle set; a flushed operand never reports inexact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                fflag_nx <= 1'b0;
    else if (csr_clr_nx)       fflag_nx <= 1'b0;
    else if (s1_adv && !flush) fflag_nx <= fflag_nx | s1_op.rbit | s1_op.tail;
  end

  assign rnd_A      = s1_op.a;
  assign rnd_rbit   = s1_op.rbit;
  assign rnd_tail   = s1_op.tail;
  assign rnd_rndbit = s1_op.rndbit;
  assign rnd_rmode  = s1_op.rmode;
  assign rnd_isDBL  = s1_op.fmt[3];
  assign rnd_isEXT  = s1_op.fmt[2];
  assign rnd_toDBL  = s1_op.fmt[1];
  assign rnd_toSNG  = s1_op.fmt[0];

  assign out_vld = s2_vld;
  assign out_B   = s2_b;
  assign out_tag = s2_tag;
  assign out_src = s2_src;

endmodule

// File: tb/tb_fprnd_sched.sv
// Directed bench for fprnd_sched; fprnd is replaced by a simple reference function.
module tb_fprnd_sched;

  logic         clk, rst_n;
  logic [2:0]   req_vld, req_rdy;
  logic [242:0] req_A;
  logic [2:0]   req_rbit, req_tail, req_rndbit;
  logic [8:0]   req_rmode;
  logic [11:0]  req_fmt;
  logic [26:0]  req_tag;
  logic [2:0]   csr_rmode;
  logic         csr_clr_nx, flush;
  logic [80:0]  rnd_A;
  logic         rnd_rbit, rnd_tail, rnd_rndbit;
  logic [2:0]   rnd_rmode;
  logic         rnd_isDBL, rnd_isEXT, rnd_toDBL, rnd_toSNG;
  logic [79:0]  rnd_B;
  logic         out_vld, out_rdy;
  logic [79:0]  out_B;
  logic [8:0]   out_tag;
  logic [1:0]   out_src;
  logic         fflag_nx;

  logic [80:0]  a_in[3];
  logic [2:0]   rm_in[3];
  logic [3:0]   fmt_in[3];
  logic [8:0]   tag_in[3];

  int n_chk, n_fail, src;

  fprnd_sched #(.NREQ(3), .TAGW(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_A(req_A),
    .req_rbit(req_rbit), .req_tail(req_tail), .req_rndbit(req_rndbit),
    .req_rmode(req_rmode), .req_fmt(req_fmt), .req_tag(req_tag),
    .csr_rmode(csr_rmode), .csr_clr_nx(csr_clr_nx), .flush(flush),
    .rnd_A(rnd_A), .rnd_rbit(rnd_rbit), .rnd_tail(rnd_tail), .rnd_rndbit(rnd_rndbit),
    .rnd_rmode(rnd_rmode), .rnd_isDBL(rnd_isDBL), .rnd_isEXT(rnd_isEXT),
    .rnd_toDBL(rnd_toDBL), .rnd_toSNG(rnd_toSNG), .rnd_B(rnd_B),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_B(out_B), .out_tag(out_tag),
    .out_src(out_src), .fflag_nx(fflag_nx)
  );

  function automatic logic [79:0] fprnd_ref(input logic [80:0] a, input logic [2:0] rm,
                                            input logic rb);
    return a[79:0] ^ {76'd0, rm, rb};
  endfunction

  assign rnd_B     = fprnd_ref(rnd_A, rnd_rmode, rnd_rbit);
  assign req_A     = {a_in[2], a_in[1], a_in[0]};
  assign req_rmode = {rm_in[2], rm_in[1], rm_in[0]};
  assign req_fmt   = {fmt_in[2], fmt_in[1], fmt_in[0]};
  assign req_tag   = {tag_in[2], tag_in[1], tag_in[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; flush = 1'b0; csr_clr_nx = 1'b0; csr_rmode = 3'b000; out_rdy = 1'b1;
    req_vld = 3'b111; req_rbit = '0; req_tail = '0; req_rndbit = '0;
    a_in[0] = 81'h0_3FF0_0000_0000_0001;  a_in[1] = 81'h1_4008_0000_0000_0000_0010;
    a_in[2] = 81'h0_C010_0000_0000_0000_0020;
    for (int i = 0; i < 3; i++) begin
      rm_in[i] = 3'(i); fmt_in[i] = 4'b1000; tag_in[i] = 9'(10 + i);
    end

    // reset state, with requests pending to show req_rdy is held low
    #12;
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_req_rdy", req_rdy, 3'b000);
    chk("rst_fflag", fflag_nx, 1'b0);
    chk("rst_out_B", out_B, 80'd0);
    chk("rst_out_tag", out_tag, 9'd0);
    chk("rst_rnd_A", rnd_A, 81'd0);
    chk("rst_rnd_rmode", rnd_rmode, 3'd0);
    req_vld = 3'b000;
    nxt(); rst_n = 1'b1;

    // single FADD request
    tag_in[0] = 9'd5; req_vld = 3'b001;
    @(negedge clk); chk("t1_rdy", req_rdy, 3'b001);
    nxt(); req_vld = 3'b000;
    @(negedge clk);
    chk("t1_rnd_A", rnd_A, a_in[0]);
    chk("t1_isDBL", rnd_isDBL, 1'b1);
    chk("t1_toSNG", rnd_toSNG, 1'b0);
    chk("t1_no_early_vld", out_vld, 1'b0);
    nxt(); @(negedge clk);
    chk("t1_out_vld", out_vld, 1'b1);
    chk("t1_out_src", out_src, 2'd0);
    chk("t1_out_tag", out_tag, 9'd5);
    chk("t1_out_B", out_B, fprnd_ref(a_in[0], 3'b000, 1'b0));
    nxt(); @(negedge clk);
    chk("t1_drained", out_vld, 1'b0);
    tag_in[0] = 9'd10;

    // reset pulse brings ptr back to 0, then round-robin with all requesters valid
    nxt(); rst_n = 1'b0;
    nxt(); rst_n = 1'b1;
    req_vld = 3'b111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 6) chk("rr_rdy", req_rdy, 3'b001 << (k % 3));
      if (k >= 2) begin
        src = (k - 2) % 3;
        chk("rr_vld", out_vld, 1'b1);
        chk("rr_src", out_src, src);
        chk("rr_tag", out_tag, 10 + src);
        chk("rr_B", out_B, fprnd_ref(a_in[src], rm_in[src], 1'b0));
      end
      nxt();
      if (k == 5) req_vld = 3'b000;
    end
    @(negedge clk); chk("rr_idle", out_vld, 1'b0);

    // dynamic rounding mode is sampled at grant time
    nxt();
    rm_in[1] = 3'b111; csr_rmode = 3'b010; req_vld = 3'b010;
    @(negedge clk); chk("dyn_rdy", req_rdy, 3'b010);
    nxt(); req_vld = 3'b000; csr_rmode = 3'b001;
    @(negedge clk); chk("dyn_rmode", rnd_rmode, 3'b010);
    nxt(); rm_in[2] = 3'b100; req_vld = 3'b100;
    @(negedge clk);
    chk("dyn_out_B", out_B, fprnd_ref(a_in[1], 3'b010, 1'b0));
    chk("dyn_out_src", out_src, 2'd1);
    nxt(); req_vld = 3'b000;
    @(negedge clk); chk("static_rmode", rnd_rmode, 3'b100);
    rm_in[1] = 3'b001; rm_in[2] = 3'b010;
    nxt(); nxt();

    // stall: fill S2 and S1, hold out_rdy low, then release
    out_rdy = 1'b0; req_vld = 3'b111;
    @(negedge clk); chk("st_rdy0", req_rdy, 3'b001);
    nxt();
    @(negedge clk); chk("st_rdy1", req_rdy, 3'b010);
    nxt();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("st_rdy_low", req_rdy, 3'b000);
      chk("st_vld", out_vld, 1'b1);
      chk("st_B_stable", out_B, fprnd_ref(a_in[0], rm_in[0], 1'b0));
      chk("st_rnd_A", rnd_A, a_in[1]);
      nxt();
    end
    out_rdy = 1'b1;
    @(negedge clk);
    chk("rel_src0", out_src, 2'd0);
    chk("rel_rdy", req_rdy, 3'b100);
    nxt(); req_vld = 3'b000;
    @(negedge clk);
    chk("rel_vld1", out_vld, 1'b1);
    chk("rel_src1", out_src, 2'd1);
    nxt();
    @(negedge clk); chk("rel_src2", out_src, 2'd2);
    nxt();
    @(negedge clk); chk("rel_idle", out_vld, 1'b0);

    // sticky inexact: set, then clear racing a second set
    nxt(); req_rbit = 3'b001; req_vld = 3'b001;
    @(negedge clk); chk("nx_rdy", req_rdy, 3'b001);
    nxt(); req_vld = 3'b000;
    @(negedge clk); chk("nx_not_yet", fflag_nx, 1'b0);
    nxt();
    @(negedge clk); chk("nx_set", fflag_nx, 1'b1);
    req_vld = 3'b001;
    nxt(); req_vld = 3'b000; csr_clr_nx = 1'b1;
    nxt(); csr_clr_nx = 1'b0;
    @(negedge clk); chk("nx_clr_prio", fflag_nx, 1'b0);
    req_rbit = 3'b000;
    nxt();

    // flush with S1 and S2 full; ptr is 1 here
    req_rbit = 3'b100; out_rdy = 1'b0; req_vld = 3'b111;
    @(negedge clk); chk("fl_rdy1", req_rdy, 3'b010);
    nxt();
    @(negedge clk); chk("fl_rdy2", req_rdy, 3'b100);
    nxt(); flush = 1'b1;
    @(negedge clk); chk("fl_rdy_low", req_rdy, 3'b000);
    nxt(); flush = 1'b0; req_vld = 3'b000; out_rdy = 1'b1;
    @(negedge clk); chk("fl_vld0", out_vld, 1'b0);
    nxt();
    @(negedge clk);
    chk("fl_no_result", out_vld, 1'b0);
    chk("fl_nx_kept", fflag_nx, 1'b0);
    nxt(); req_rbit = 3'b000; req_vld = 3'b111;
    @(negedge clk); chk("fl_ptr", req_rdy, 3'b001);
    nxt(); req_vld = 3'b000;
    nxt();
    @(negedge clk);
    chk("fl_new_vld", out_vld, 1'b1);
    chk("fl_new_tag", out_tag, 9'd10);

    // asynchronous reset mid-stream; ptr is 1, requester 1 is inexact
    nxt(); req_rbit = 3'b010; req_vld = 3'b111;
    nxt(); nxt(); nxt();
    chk("ar_pre_vld", out_vld, 1'b1);
    chk("ar_pre_nx", fflag_nx, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_vld", out_vld, 1'b0);
    chk("ar_rdy", req_rdy, 3'b000);
    chk("ar_B", out_B, 80'd0);
    chk("ar_src", out_src, 2'd0);
    chk("ar_tag", out_tag, 9'd0);
    chk("ar_rnd_A", rnd_A, 81'd0);
    chk("ar_nx", fflag_nx, 1'b0);
    req_vld = 3'b000;
    nxt(); rst_n = 1'b1;
    nxt();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/fprnd_sched.md
# fprnd_sched

Round-robin scheduler that shares one `fprnd` rounding datapath among three FP producers: FADD, FMUL and convert. It arbitrates rounding requests and holds the granted operand in an issue register that drives the shared `fprnd` instance. It captures `fprnd`'s combinational result in a result register with valid/ready backpressure, resolves dynamic rounding mode, and accumulates a sticky inexact flag. It sits between the FP execute pipes and FP writeback.

## Interface
Parameters:
- NREQ, 3, number of requesters; index 0 = FADD, 1 = FMUL, 2 = CVT
- TAGW, 9, width of the destination tag carried alongside each operand

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  NREQ  request valid, one bit per requester
- req_rdy  out  NREQ  request accepted this cycle; a handshake completes when vld & rdy
- req_A  in  NREQ*81  unrounded operand; requester i occupies bits [81*i+80:81*i]
- req_rbit, req_tail, req_rndbit  in  NREQ each  round bit, sticky tail, round-position bit
- req_rmode  in  NREQ*3  rounding mode; value 3'b111 = dynamic
- req_fmt  in  NREQ*4  {isDBL,isEXT,toDBL,toSNG}
- req_tag  in  NREQ*TAGW  destination tag
- csr_rmode  in  3  dynamic rounding mode
- csr_clr_nx  in  1  clears the sticky inexact flag
- flush  in  1  kills all in-flight work
- rnd_A  out  81  to `fprnd` A
- rnd_rbit, rnd_tail, rnd_rndbit  out  1 each  to `fprnd`
- rnd_rmode  out  3  resolved rounding mode, never 3'b111
- rnd_isDBL, rnd_isEXT, rnd_toDBL, rnd_toSNG  out  1 each  to `fprnd`
- rnd_B  in  80  combinational result from `fprnd`
- out_vld  out  1  result valid
- out_rdy  in  1  writeback ready
- out_B  out  80  rounded result
- out_tag  out  TAGW  tag of the result
- out_src  out  2  index of the requester that produced the result
- fflag_nx  out  1  sticky inexact flag

## Operation
- Pipeline stage S1 is the issue register, holding valid, payload and source index; its payload drives all `rnd_*` outputs.
- Pipeline stage S2 is the result register, holding valid, B, tag and source index; it drives all `out_*` outputs.
- Stall conditions:
  - s2_stall = S2.vld & ~out_rdy.
  - s1_adv = S1.vld & ~s2_stall.
  - S1 may load when ~S1.vld | s1_adv.
- Arbitration:
  - When S1 may load and flush is low, exactly one requester is granted.
  - The grant goes to the first set req_vld bit scanning from ptr upward, wrapping modulo NREQ.
  - req_rdy is one-hot on the granted index and all zero otherwise.
  - req_rdy is combinational from req_vld, ptr and the stall state.
- Pointer: on a grant to index g, ptr <= (g+1) mod NREQ. With no grant, ptr holds.
- Mode resolution at S1 load: stored rmode = (req_rmode == 3'b111) ? csr_rmode : req_rmode. csr_rmode is sampled at grant time; later CSR writes do not affect an operand already in S1.
- Result capture: on s1_adv, S2 loads {rnd_B, S1.tag, S1.src} and S2.vld <= 1. Otherwise, when out_vld & out_rdy, S2.vld <= 0.
- Sticky inexact flag:
  - On s1_adv, fflag_nx <= fflag_nx | S1.rbit | S1.tail.
  - csr_clr_nx clears the flag and has priority over a same-cycle set.
- Flush:
  - Clears S1.vld and S2.vld at the next edge.
  - Forces req_rdy = 0 in that cycle.
  - Leaves ptr and fflag_nx unchanged; a flushed S1 operand does not set fflag_nx.
- Format bits pass through unchanged. The scheduler does not check that they are legal combinations.

## Timing
- Reset values: out_vld=0, req_rdy=0, S1.vld=0, ptr=0, fflag_nx=0, out_B=0, out_tag=0, out_src=0, and all rnd_* = 0.
- Latency: a request handshaken in cycle t appears on out_vld in cycle t+2, given no stall.
- Throughput is one result per cycle under continuous out_rdy.
- While S2 is stalled:
  - S2 holds its value.
  - S1 holds its value and keeps driving `rnd_*` stably.
  - req_rdy = 0 if S1.vld.
  - One further request may be accepted only if S1 is empty.
- out_B, out_tag and out_src are stable while out_vld & ~out_rdy.
- A simultaneous S2 drain and S1 advance in the same cycle results in S2 reloaded and out_vld staying 1.
- Asserting rst_n low mid-operation drops all in-flight results immediately, with no out_vld pulse.

## Test plan
- Single request from FADD, A=81'h0_3FF0_0000_0000_0001, rmode=0, isDBL=1, out_rdy=1 -> req_rdy[0] in cycle t; out_vld in cycle t+2 with out_src=0 and out_B equal to a reference `fprnd` result for the same inputs.
- All three req_vld held high for 6 cycles with out_rdy=1 -> grant order 0,1,2,0,1,2; out_src follows the same order; one result per cycle.
- req_rmode=3'b111 with csr_rmode=3'b010 -> rnd_rmode=3'b010 while the operand is in S1. csr_rmode changing to 3'b001 after the grant -> rnd_rmode stays 3'b010.
- Fill S1 and S2, then hold out_rdy=0 for 5 cycles with all requesters valid -> req_rdy=0 throughout and out_B stable. Releasing out_rdy -> two results on consecutive cycles, then arbitration resumes.
- rbit=1 on one operand -> fflag_nx rises the cycle after s1_adv. Asserting csr_clr_nx in the same cycle as a second inexact advance -> fflag_nx=0.
- flush with S1 and S2 full -> out_vld=0 next cycle, no result for the flushed tags, ptr unchanged. Asserting rst_n low mid-stream -> all outputs at reset values asynchronously.
